// File: rtl/mem_load_unit_if.sv
// ---------------------------------------------------------------------------
// mem_load_unit_if
// Groups the request, data-memory bus and response signals of mem_load_unit.
//   Request : ReqValid/ReqReady handshake, ReqWrite, ReqAddr, ReqFunct3, ReqWData
//   Bus     : BusReq/BusAck handshake, BusWe, BusAddr, BusBe, BusWData, BusRData
//   Response: RspValid pulse, RspRawMem, RspMisalign, RspTimeout
// Modport slave is the load unit's view: it serves requests and drives the
// bus. Modport master is the surrounding pipeline and memory.
// ---------------------------------------------------------------------------
interface mem_load_unit_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [31:0] ReqAddr;
  logic [2:0]  ReqFunct3;
  logic [31:0] ReqWData;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [3:0]  BusBe;
  logic [31:0] BusWData;
  logic        BusAck;
  logic [31:0] BusRData;
  logic        RspValid;
  logic [31:0] RspRawMem;
  logic        RspMisalign;
  logic        RspTimeout;

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqFunct3, ReqWData, BusAck, BusRData,
    output ReqReady, BusReq, BusWe, BusAddr, BusBe, BusWData,
    output RspValid, RspRawMem, RspMisalign, RspTimeout
  );

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqFunct3, ReqWData, BusAck, BusRData,
    input  ReqReady, BusReq, BusWe, BusAddr, BusBe, BusWData,
    input  RspValid, RspRawMem, RspMisalign, RspTimeout
  );
endinterface

// File: rtl/mem_load_unit.sv
// ---------------------------------------------------------------------------
// mem_load_unit
// Data-memory access stage. Accepts one load/store at a time, runs a
// request/acknowledge cycle on a word-wide bus, and returns load data
// right-justified and zero-filled above the access size. Misaligned or
// illegal-size accesses and bus timeouts are reported instead of issued.
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - synchronous reset, active-low
//   io     - mem_load_unit_if.slave (request, bus and response signals)
// Parameter:
//   TIMEOUT - max cycles BusReq waits for BusAck (2..255)
// ---------------------------------------------------------------------------
module mem_load_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_load_unit_if.slave  io
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_ready;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_raw;
  logic        r_rsp_mis;
  logic        r_rsp_to;

  logic [1:0]  w_size;
  logic [1:0]  w_off;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic        w_unused;

  // funct3[2] (signedness) belongs to the sign extender downstream.
  assign w_unused = io.ReqFunct3[2];

  assign w_size = io.ReqFunct3[1:0];
  assign w_off  = io.ReqAddr[1:0];

  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = io.ReqWData;
    case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{io.ReqWData[7:0]}};
      end
      2'b01: begin
        w_misalign = w_off[0];
        w_be       = 4'b0011 << w_off;
        w_wdata    = {2{io.ReqWData[15:0]}};
      end
      2'b10: w_misalign = (w_off != 2'b00);
      default: w_misalign = 1'b1;
    endcase
  end

  // Bring the addressed lane(s) down to bit 0, then clear everything above
  // the access size; sign extension happens in the next stage.
  assign w_shifted = io.BusRData >> {r_off, 3'b000};

  always_comb begin
    case (r_size)
      2'b00:   w_load = {24'b0, w_shifted[7:0]};
      2'b01:   w_load = {16'b0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_size      <= '0;
      r_off       <= '0;
      r_ready     <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_raw   <= '0;
      r_rsp_mis   <= 1'b0;
      r_rsp_to    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (io.ReqValid && r_ready) begin
            r_ready <= 1'b0;
            if (w_misalign) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_mis   <= 1'b1;
            end else begin
              r_state     <= S_BUS;
              r_cnt       <= '0;
              r_size      <= w_size;
              r_off       <= w_off;
              r_bus_req   <= 1'b1;
              r_bus_we    <= io.ReqWrite;
              r_bus_addr  <= {io.ReqAddr[31:2], 2'b00};
              r_bus_be    <= w_be;
              r_bus_wdata <= w_wdata;
            end
          end
        end
        S_BUS: begin
          // Ack is checked first so an ack in the last allowed cycle wins.
          if (io.BusAck || r_cnt == LAST_CNT) begin
            r_state     <= S_RESP;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_rsp_valid <= 1'b1;
            if (io.BusAck) begin
              r_rsp_raw <= r_bus_we ? 32'd0 : w_load;
            end else begin
              r_rsp_to  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_raw   <= '0;
          r_rsp_mis   <= 1'b0;
          r_rsp_to    <= 1'b0;
        end
      endcase
    end
  end

  assign io.ReqReady    = r_ready;
  assign io.BusReq      = r_bus_req;
  assign io.BusWe       = r_bus_we;
  assign io.BusAddr     = r_bus_addr;
  assign io.BusBe       = r_bus_be;
  assign io.BusWData    = r_bus_wdata;
  assign io.RspValid    = r_rsp_valid;
  assign io.RspRawMem   = r_rsp_raw;
  assign io.RspMisalign = r_rsp_mis;
  assign io.RspTimeout  = r_rsp_to;

endmodule

// File: doc/mem_load_unit.md
# mem_load_unit

Data-memory access stage between the execute stage and the load sign extender. Accepts one load or store request at a time, drives a word-wide data-memory bus with a variable-latency request/acknowledge handshake, and returns load data right-justified and zero-filled above the access size. The sign extender consumes that result as its raw memory word. Misaligned accesses and bus timeouts are reported as fault flags instead of being issued.

## Interface
Parameters:
- TIMEOUT, 16, maximum cycles BusReq stays high waiting for BusAck; range 2..255

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous reset, active-low
- ReqValid  in  1  request present
- ReqReady  out  1  unit can accept a request
- ReqWrite  in  1  1 = store, 0 = load
- ReqAddr  in  32  byte address
- ReqFunct3  in  3  access type; [1:0] size (00 byte, 01 half, 10 word, 11 illegal); [2] ignored here
- ReqWData  in  32  store data, right-justified
- BusReq  out  1  bus request, held until ack or timeout
- BusWe  out  1  bus write enable
- BusAddr  out  32  word address, {ReqAddr[31:2], 2'b00}
- BusBe  out  4  byte enables
- BusWData  out  32  lane-replicated store data
- BusAck  in  1  bus completion; ignored when BusReq = 0
- BusRData  in  32  read word, valid when BusAck = 1
- RspValid  out  1  one-cycle completion pulse
- RspRawMem  out  32  load result; 0 for stores and faults
- RspMisalign  out  1  access misaligned or size illegal
- RspTimeout  out  1  no BusAck within TIMEOUT cycles

## Operation
- FSM states are IDLE, BUS, and RESP. Reset enters IDLE.
- IDLE: ReqReady = 1. A request is accepted when ReqValid & ReqReady is sampled at a rising edge. The unit latches ReqWrite, ReqAddr, ReqFunct3, and ReqWData at acceptance.
- Misaligned cases: size 11; half with addr[0] = 1; word with addr[1:0] != 0. Any of these goes IDLE→RESP with RspMisalign = 1. No bus cycle is issued.
- Aligned requests go IDLE→BUS and clear the wait counter.
- BUS: BusReq = 1. BusAddr, BusWe, BusBe, and BusWData are held stable from latched values.
  - BusAck = 1: capture BusRData, then go to RESP.
  - No ack: increment the counter. When the counter reaches TIMEOUT-1 without an ack, go to RESP with RspTimeout = 1.
- RESP: RspValid = 1 for exactly one cycle, then IDLE. Flags and RspRawMem are valid only while RspValid = 1 and are 0 otherwise.
- Byte enables use off = addr[1:0]:
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
- Store data lanes:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load result: shifted = BusRData >> (8*off), then masked.
  - byte: keep [7:0]
  - half: keep [15:0]
  - word: all 32 bits
  - All bits above the access size are 0. Sign extension is not performed here.
- Stores return RspRawMem = 0.

## Timing
- Reset values: ReqReady = 0 while rst_n = 0, 1 in the first cycle after release. BusReq, BusWe, BusBe, BusWData, BusAddr, RspValid, RspRawMem, RspMisalign, and RspTimeout are all 0.
- Aligned access, accepted at edge E0:
  - BusReq is high from cycle E0+1.
  - If BusAck arrives in the cycle ending at edge Ek (k ≥ 1), RspValid is high during cycle Ek+1.
  - ReqReady is high again in cycle Ek+2.
  - Minimum accept-to-RspValid latency is 2 cycles with zero-wait ack.
- Misaligned access: RspValid is high in cycle E0+1. ReqReady is high in cycle E0+2.
- Timeout: BusReq is high for exactly TIMEOUT cycles, then drops in the RESP cycle. A BusAck arriving after BusReq falls is ignored.
- BusAck in the last allowed cycle (counter = TIMEOUT-1) counts as success. Ack has priority over timeout.
- Throughput: at most one outstanding access. ReqValid while ReqReady = 0 is not accepted and has no effect.
- Reset mid-BUS: BusReq is 0 from the next edge, no RspValid is emitted, and latched state is discarded.
- Simultaneous rst_n = 0 and ReqValid = 1: reset wins and the request is not accepted.

## Test plan
- Load byte, addr 0x1003, BusRData 0xA1B2C3D4, ack on the first BusReq cycle. Expect BusAddr 0x1000, BusBe 4'b1000, RspRawMem 0x000000A1, and RspValid 2 cycles after accept.
- Store half, addr 0x2002, wdata 0x1234ABCD. Expect BusWe 1, BusBe 4'b1100, BusWData 0xABCDABCD, RspRawMem 0.
- Load word, addr 0x3001. Expect no BusReq ever, RspValid + RspMisalign in the next cycle, RspRawMem 0. Repeat with funct3 = 3'b011 at addr 0x3000 and expect the same response.
- Load half, addr 0x40, ack delayed 5 cycles, TIMEOUT = 16. Expect BusReq high for 6 cycles with stable address, RspRawMem = BusRData[15:0] zero-extended.
- Never assert BusAck, TIMEOUT = 4. Expect BusReq high for exactly 4 cycles, then RspValid + RspTimeout. A late BusAck one cycle afterwards has no effect. Ack in the 4th cycle instead gives success.
- Assert rst_n = 0 during BUS wait. Expect BusReq low next cycle, no RspValid, and ReqReady = 1 after release. A back-to-back request then completes normally.
